// File: rtl/trackball_pkg.sv
// -----------------------------------------------------------------------------
// trackball_pkg
// Shared types and helpers for the trackball encoder.
//   mode_e    : output encoding (DIRCLK = direction + count clock, QUAD = Gray A/B)
//   PH0..PH3  : quadrature phase sequence for forward motion, as {A,B}
//   sat_add   : acc - step + delta, computed one bit wider than the datapath and
//               clipped to +/-(2^(acc_w-1)-1) so the most-negative code never appears
//   gray_step : advance or reverse one quadrature phase
// -----------------------------------------------------------------------------
package trackball_pkg;

    typedef enum logic {
        DIRCLK = 1'b0,
        QUAD   = 1'b1
    } mode_e;

    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b01;
    localparam logic [1:0] PH2 = 2'b11;
    localparam logic [1:0] PH3 = 2'b10;

    // Working width of the saturating adder. Accumulators up to 31 bits fit,
    // since the sum is formed one bit wider than this.
    localparam int SAT_W = 32;

    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] step,
        input logic signed [SAT_W-1:0] delta,
        input int                      acc_w
    );
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] lim;
        sum = (SAT_W+1)'(acc) - (SAT_W+1)'(step) + (SAT_W+1)'(delta);
        lim = ((SAT_W+1)'(1) << (acc_w - 1)) - (SAT_W+1)'(1);
        if (sum > lim) begin
            sum = lim;
        end else if (sum < -lim) begin
            sum = -lim;
        end
        return sum[SAT_W-1:0];
    endfunction

    function automatic logic [1:0] gray_step(
        input logic [1:0] ph,
        input logic       up
    );
        logic [1:0] fwd;
        logic [1:0] bwd;
        case (ph)
            PH0: begin fwd = PH1; bwd = PH3; end
            PH1: begin fwd = PH2; bwd = PH0; end
            PH2: begin fwd = PH3; bwd = PH1; end
            default: begin fwd = PH0; bwd = PH2; end
        endcase
        return up ? fwd : bwd;
    endfunction

endpackage

// File: rtl/trackball_axis.sv
// -----------------------------------------------------------------------------
// trackball_axis
// One axis: signed movement accumulator, one-count-per-tick drain and output
// encoder (DIRCLK or QUAD selected at elaboration).
// Ports:
//   clk_sys, reset_n : clock, asynchronous active-low reset
//   tick             : drain tick from the shared rate counter
//   accept           : a packet is accepted this cycle (already masked by clear)
//   clear            : synchronous flush of the accumulator
//   delta            : raw signed delta for this axis
//   flip             : negate the incoming delta
//   out_a, out_b     : DIRCLK dir/clock or QUAD phase A/B (registered)
//   busy             : accumulator non-zero (registered from the accumulator)
// -----------------------------------------------------------------------------
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int    DELTA_W = 9,
    parameter int    ACC_W   = 12,
    parameter mode_e MODE    = DIRCLK
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               accept,
    input  logic               clear,
    input  logic [DELTA_W-1:0] delta,
    input  logic               flip,
    output logic               out_a,
    output logic               out_b,
    output logic               busy
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [SAT_W-1:0] delta_ext;
    logic signed [SAT_W-1:0] delta_acc;
    logic signed [SAT_W-1:0] step;
    logic                    step_en;
    logic                    step_up;
    logic                    out_a_q;
    logic                    out_a_d;
    logic                    out_b_q;
    logic                    out_b_d;
    logic                    busy_q;

    // Steps are decided from the registered accumulator only, so a packet
    // never reaches the outputs in the cycle it is accepted.
    always_comb begin
        delta_ext = SAT_W'(signed'(delta));
        delta_acc = '0;
        if (accept) begin
            // Widened before negation, so -(most negative) stays positive.
            delta_acc = flip ? -delta_ext : delta_ext;
        end
        step_en = tick && !clear && (acc_q != '0);
        step_up = ~acc_q[ACC_W-1];
        step    = '0;
        if (step_en) begin
            step = step_up ? SAT_W'(1) : -SAT_W'(1);
        end
        if (clear) begin
            acc_d = '0;
        end else begin
            acc_d = ACC_W'(sat_add(SAT_W'(acc_q), step, delta_acc, ACC_W));
        end
    end

    if (MODE == QUAD) begin : g_quad
        always_comb begin
            {out_a_d, out_b_d} = {out_a_q, out_b_q};
            if (step_en) begin
                {out_a_d, out_b_d} = gray_step({out_a_q, out_b_q}, step_up);
            end
        end
    end else begin : g_dirclk
        always_comb begin
            out_a_d = out_a_q;
            out_b_d = out_b_q;
            if (step_en) begin
                out_a_d = step_up;
                out_b_d = ~out_b_q;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            out_a_q <= 1'b0;
            out_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
            busy_q  <= (acc_q != '0);
        end
    end

    assign out_a = out_a_q;
    assign out_b = out_b_q;
    assign busy  = busy_q;

endmodule

// File: rtl/trackball_quad_gen.sv
// -----------------------------------------------------------------------------
// trackball_quad_gen
// Mouse-to-trackball encoder: accumulates signed per-axis deltas from mouse
// packets and drains them one count per rate tick as DIRCLK or quadrature.
// Parameters: NUM_AXES, DELTA_W, ACC_W (> DELTA_W, <= 31), RATE_DIV (>= 1),
//             MODE (0 = DIRCLK, 1 = QUAD).
// Ports:
//   clk_sys, reset_n : clock, asynchronous active-low reset
//   mouse_toggle     : packet strobe, any level change marks a new packet
//   delta            : packed signed deltas, axis i at [i*DELTA_W +: DELTA_W]
//   flip             : per-axis delta negate
//   clear            : flush accumulators and rate counter (drops a coincident packet)
//   out_a, out_b     : per-axis encoder outputs
//   busy             : per-axis accumulator non-zero
// -----------------------------------------------------------------------------
module trackball_quad_gen
    import trackball_pkg::*;
#(
    parameter int NUM_AXES = 2,
    parameter int DELTA_W  = 9,
    parameter int ACC_W    = 12,
    parameter int RATE_DIV = 1,
    parameter int MODE     = 0
) (
    input  logic                        clk_sys,
    input  logic                        reset_n,
    input  logic                        mouse_toggle,
    input  logic [NUM_AXES*DELTA_W-1:0] delta,
    input  logic [NUM_AXES-1:0]         flip,
    input  logic                        clear,
    output logic [NUM_AXES-1:0]         out_a,
    output logic [NUM_AXES-1:0]         out_b,
    output logic [NUM_AXES-1:0]         busy
);

    localparam mode_e          MODE_E   = (MODE == 1) ? QUAD : DIRCLK;
    localparam int             CNT_W    = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE_DIV - 1);

    logic             toggle_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick;
    logic             accept;

    assign accept = (mouse_toggle != toggle_q) && !clear;
    // With RATE_DIV = 1 the counter is pinned at 0 and tick is always high.
    assign tick   = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            toggle_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            // Tracks the strobe even during clear, so a dropped packet stays dropped.
            toggle_q <= mouse_toggle;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_axis
        trackball_axis #(
            .DELTA_W (DELTA_W),
            .ACC_W   (ACC_W),
            .MODE    (MODE_E)
        ) u_axis (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .tick    (tick),
            .accept  (accept),
            .clear   (clear),
            .delta   (delta[gi*DELTA_W +: DELTA_W]),
            .flip    (flip[gi]),
            .out_a   (out_a[gi]),
            .out_b   (out_b[gi]),
            .busy    (busy[gi])
        );
    end

endmodule

// File: doc/trackball_quad_gen.md
# trackball_quad_gen

Parametrised mouse-to-trackball encoder for arcade cores. It replaces the ad-hoc two-axis trackball logic in the top level with one instance per controller. It accumulates signed PS/2-style movement deltas per axis and drains them one count per rate tick into either direction/clock pairs (Atari trackball style) or true two-phase quadrature. It sits between hps_io mouse data and the core's trackball input bus, in the clk_sys domain.

## Interface

Parameters:
- NUM_AXES, 2, number of independent axes.
- DELTA_W, 9, width of each signed delta (sign bit is the MSB).
- ACC_W, 12, width of the signed per-axis accumulator; must satisfy ACC_W > DELTA_W.
- RATE_DIV, 1, number of clk_sys cycles per drain tick; must be ≥ 1.
- MODE, 0, output encoding: 0 = DIRCLK (direction + toggling clock), 1 = QUAD (Gray A/B).

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- mouse_toggle  in  1  packet strobe; a new packet is signalled by any change of level (ps2_mouse[24] convention).
- delta  in  NUM_AXES*DELTA_W  signed deltas, axis i at [i*DELTA_W +: DELTA_W].
- flip  in  NUM_AXES  per-axis negate of incoming delta (cocktail flip).
- clear  in  1  synchronous flush of all accumulators and the rate counter.
- out_a  out  NUM_AXES  DIRCLK: direction (1 = positive); QUAD: phase A.
- out_b  out  NUM_AXES  DIRCLK: count clock; QUAD: phase B.
- busy  out  NUM_AXES  accumulator non-zero.

## Operation

- Edge detect: toggle_q registers mouse_toggle. A packet is accepted in the cycle where mouse_toggle != toggle_q.
- Accepted delta: sign-extend to ACC_W, then negate if flip[i]. Negating the most-negative value yields 2^(DELTA_W-1), which is representable because ACC_W > DELTA_W.
- Drain tick: the rate counter runs 0..RATE_DIV-1 and tick asserts when it reaches RATE_DIV-1. With RATE_DIV=1, tick is high every cycle.
- On tick, if acc ≠ 0, a step is taken: s = +1 if acc > 0, s = -1 if acc < 0.
- Update: acc_next = sat(acc - s + d), where d is the accepted delta or 0. The sum is computed at ACC_W+1 bits and saturated to ±(2^(ACC_W-1)-1). The most-negative code is never stored.
- DIRCLK output, per step:
  - out_a ← (s > 0).
  - out_b toggles.
  - Without a step, both hold.
- QUAD output: a 2-bit phase register.
  - A step of +1 advances 00→01→11→10→00.
  - A step of -1 reverses that sequence.
  - out_a = phase[1], out_b = phase[0].
- busy[i] = (acc_i ≠ 0), registered from acc.
- clear: acc ← 0 and the rate counter ← 0. Phase/out_a/out_b are retained so no false edge is generated. A packet arriving in the same cycle as clear is discarded.

## Timing

- Reset values: all accumulators 0, toggle_q 0, rate counter 0, phase 00, out_a 0, out_b 0, busy 0.
- Latency:
  - The first output change appears on the first tick at least 1 cycle after packet acceptance. The accumulator updates at edge N, and the step is evaluated from the registered acc at edge N+1 or later.
  - busy rises 2 cycles after the accepted edge.
- Throughput: at most one count per axis per tick. A delta of magnitude k with RATE_DIV=R drains in k·R cycles when no further packets arrive.
- Simultaneous step and packet: both apply in the same cycle per the update formula. No packet is ever dropped unless clear is asserted in that cycle.
- Saturation: when the accumulator is full, excess counts are lost. The accumulator holds at the limit and continues to drain.
- Reset asserted mid-drain: all state returns to reset values immediately, asynchronously. Release is synchronised externally by the top level.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Structure

- Package trackball_pkg:
  - mode_e {DIRCLK=0, QUAD=1}.
  - Gray sequence constants PH0..PH3.
  - Saturation function sat_add(acc, step, delta) parameterised via ACC_W.
- Sub-module trackball_axis: one accumulator, step logic and output encoder per axis, instantiated NUM_AXES times in a generate loop.
- The top-level block holds the shared edge detect and rate counter.

## Test plan

- DIRCLK, RATE_DIV=1: packet with delta_x = +5 → out_b toggles 5 times on consecutive cycles, out_a = 1, busy_x falls after the 5th step.
- QUAD, RATE_DIV=4: delta_y = -3 → phase walks 00→10→11→01, one transition every 4 cycles.
- flip_x = 1, delta_x = -256 (most negative) → acc = +256, 256 positive steps.
- Saturation, ACC_W=12: four packets of +255 with no drain time (RATE_DIV large) → acc = 1020. Then eight more → acc caps at 2047 and drains to 0 exactly.
- Simultaneous: acc = 3 with a tick coinciding with a packet of delta -10 → acc = -8 next cycle. The direction output flips on the next step.
- clear asserted with a pending acc = 50 and a packet the same cycle → acc = 0, busy falls, out_a/out_b hold. A reset_n pulse mid-drain → all outputs 0 within the same cycle.
